// File: rtl/mux_pkg.sv
// Shared types and sizing helpers for the TDM slot demux.
// Imported by the deserializer top and its shadow write decoder.
package mux_pkg;

  localparam int WIDTH_DEF = 8;

  function automatic int idx_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  typedef enum logic {
    ST_IDLE,
    ST_COLLECT
  } state_t;

endpackage

// File: rtl/slot_demux_reg.sv
// Registered 1-to-WIDTH write decoder: one addressed shadow
// bit takes bit_in per enabled cycle, all others hold.
module slot_demux_reg
  import mux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  localparam int IDXW = idx_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDXW-1:0]  idx,
  input  logic             bit_in,
  output logic [WIDTH-1:0] shadow
);

  logic [WIDTH-1:0] hit;

  always_comb begin
    hit = '0;
    for (int i = 0; i < WIDTH; i++) begin
      hit[i] = we && (idx == IDXW'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (hit[i]) shadow[i] <= bit_in;
      end
    end
  end

endmodule

// File: rtl/tdm_demux_deser.sv
// Framed serial-slot to parallel-word deserializer with
// premature-restart detection; slot i lands in data_out[i].
module tdm_demux_deser
  import mux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  localparam int IDXW = idx_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic [IDXW-1:0]  slot_idx,
  output logic             busy,
  output logic             frame_err
);

  localparam logic [IDXW-1:0] LAST = IDXW'(WIDTH - 1);
  localparam logic [IDXW-1:0] ONE  = IDXW'(1);

  state_t           state;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] word;
  logic             wr_en;
  logic [IDXW-1:0]  wr_idx;

  assign busy = (state == ST_COLLECT);

  // A frame_start bit always overwrites slot 0, even mid-frame.
  assign wr_en  = bit_valid & (frame_start | busy);
  assign wr_idx = frame_start ? '0 : slot_idx;

  always_comb begin
    word = shadow;
    word[WIDTH-1] = bit_in;
  end

  slot_demux_reg #(
    .WIDTH (WIDTH)
  ) u_shadow (
    .clk    (clk),
    .rst    (rst),
    .we     (wr_en),
    .idx    (wr_idx),
    .bit_in (bit_in),
    .shadow (shadow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      slot_idx   <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (bit_valid) begin
        unique case (state)
          ST_IDLE: begin
            if (frame_start) begin
              slot_idx <= ONE;
              state    <= ST_COLLECT;
            end
          end
          ST_COLLECT: begin
            if (frame_start) begin
              frame_err <= 1'b1;
              slot_idx  <= ONE;
            end else if (slot_idx == LAST) begin
              data_out   <= word;
              data_valid <= 1'b1;
              slot_idx   <= '0;
              state      <= ST_IDLE;
            end else begin
              slot_idx <= slot_idx + ONE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux_deser.sv
// Directed bench for tdm_demux_deser with a bit-count model.
module tb_tdm_demux_deser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_start = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic [2:0] slot_idx;
  logic       busy;
  logic       frame_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_err = 0;

  int   q_cyc[$];
  logic [7:0] q_val[$];

  int         m_cnt = 0;
  logic [7:0] m_acc = '0;
  logic [7:0] m_data = '0;
  logic       m_valid = 1'b0;
  logic       m_err = 1'b0;

  tdm_demux_deser #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .slot_idx    (slot_idx),
    .busy        (busy),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Model: count accepted bits of the current frame, store by position.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0;
      m_acc = '0;
      m_data = '0;
      m_valid = 1'b0;
      m_err = 1'b0;
    end else begin
      m_valid = 1'b0;
      m_err = 1'b0;
      if (bit_valid) begin
        if (frame_start) begin
          if (m_cnt > 0) m_err = 1'b1;
          m_acc = '0;
          m_acc[0] = bit_in;
          m_cnt = 1;
        end else if (m_cnt > 0) begin
          m_acc[m_cnt] = bit_in;
          m_cnt++;
          if (m_cnt == 8) begin
            m_data = m_acc;
            m_valid = 1'b1;
            m_cnt = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("data_out", data_out, m_data);
    chk("data_valid", data_valid, m_valid);
    chk("frame_err", frame_err, m_err);
    chk("busy", busy, m_cnt > 0);
    chk("slot_idx", slot_idx, m_cnt);
    if (data_valid) begin
      q_val.push_back(data_out);
      q_cyc.push_back(cyc);
    end
    if (frame_err) n_err++;
  end

  task automatic drive(input logic fs, input logic bv,
                       input logic b);
    @(negedge clk);
    frame_start = fs;
    bit_valid = bv;
    bit_in = b;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic frame(input logic [7:0] v, input int gap_at,
                       input int gap, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      drive(i == 0, 1'b1, v[i]);
      if (i == gap_at) begin
        for (int g = 0; g < gap; g++) begin
          drive(1'b0, 1'b0, 1'b0);
          chk("gap_busy", busy, 1'b1);
        end
      end
    end
  endtask

  task automatic pop(input string name, input logic [7:0] exp);
    total++;
    if (q_val.size() == 0) begin
      bad++;
      $display("FAIL %s: got no word want %0h", name, exp);
    end else begin
      void'(q_cyc.pop_front());
      chk(name, q_val.pop_front(), exp);
    end
  endtask

  initial begin
    int c0;
    int c1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_data", data_out, 8'h00);
    chk("rst_valid", data_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_idx", slot_idx, 3'd0);
    chk("rst_err", frame_err, 1'b0);

    frame(8'hAA, -1, 0, 8);
    idle(2);
    chk("aa_count", q_val.size(), 1);
    pop("aa_word", 8'hAA);
    chk("aa_noerr", n_err, 0);

    frame(8'hD3, 3, 2, 8);
    idle(2);
    pop("d3_word", 8'hD3);

    frame(8'hAA, -1, 0, 8);
    frame(8'hD3, -1, 0, 8);
    idle(2);
    chk("b2b_count", q_val.size(), 2);
    if (q_cyc.size() == 2) begin
      c0 = q_cyc[0];
      c1 = q_cyc[1];
      chk("b2b_gap", c1 - c0, 8);
    end
    pop("b2b_first", 8'hAA);
    pop("b2b_second", 8'hD3);

    n_err = 0;
    frame(8'h55, -1, 0, 5);
    frame(8'h3C, -1, 0, 7);
    chk("abort_hold", data_out, 8'hD3);
    drive(1'b0, 1'b1, 1'b0);
    idle(2);
    chk("abort_err", n_err, 1);
    pop("abort_word", 8'h3C);

    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    idle(1);
    chk("stray_busy", busy, 1'b0);
    chk("stray_data", data_out, 8'h3C);
    chk("stray_none", q_val.size(), 0);

    frame(8'h0F, -1, 0, 4);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_data", data_out, 8'h00);
    chk("arst_busy", busy, 1'b0);
    chk("arst_idx", slot_idx, 3'd0);
    chk("arst_valid", data_valid, 1'b0);
    @(negedge clk);
    frame_start = 1'b0;
    bit_valid = 1'b0;
    bit_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    frame(8'hFF, -1, 0, 8);
    idle(2);
    pop("ff_word", 8'hFF);
    chk("ff_none", q_val.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tdm_demux_deser.md
Name: tdm_demux_deser

Overview:
- Receive-side counterpart of the 8:1 select mux.
- The transmit end walks sel = 0..WIDTH-1 and sends one selected bit per slot. This block reassembles the slots into a WIDTH-bit word, so slot i lands in data_out[i].
- It sits between the serial slot link and the parallel register consumers.
- It provides a framed, registered 1-to-WIDTH demux with frame-error detection.

Parameters:
- WIDTH, 8, number of slots per frame; legal range 2..64.
- IDXW, $clog2(WIDTH), width of the slot index (derived; not for override).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- frame_start  input  1  marks the bit on bit_in as slot 0. Qualified by bit_valid.
- bit_valid  input  1  bit_in carries a slot bit this cycle.
- bit_in  input  1  serial slot data (the selected mux output).
- data_out  output  WIDTH  last complete reassembled word. Holds between frames.
- data_valid  output  1  one-cycle pulse; data_out was updated this cycle.
- slot_idx  output  IDXW  index the next accepted bit will be written to.
- busy  output  1  high while a frame is partially collected.
- frame_err  output  1  one-cycle pulse on a protocol violation (see below).

Behaviour:
- Reset (async assert, sync release): all outputs are 0. State is IDLE and the shadow register is 0.
- Two states: IDLE and COLLECT. busy = (state == COLLECT).
- IDLE, bit_valid & frame_start:
  - shadow[0] <= bit_in
  - slot_idx <= 1
  - next state COLLECT
- IDLE, bit_valid without frame_start: bit ignored. No state change, no error.
- Any state, frame_start without bit_valid: ignored. No error.
- COLLECT, bit_valid & !frame_start, slot_idx < WIDTH-1: shadow[slot_idx] <= bit_in and slot_idx increments.
- COLLECT, bit_valid & !frame_start, slot_idx == WIDTH-1 (final slot):
  - data_out <= shadow with bit WIDTH-1 replaced by bit_in
  - data_valid = 1 for exactly the next cycle
  - slot_idx <= 0
  - next state IDLE
- COLLECT, bit_valid & frame_start (premature restart):
  - frame_err pulses for one cycle
  - partial frame discarded; data_out unchanged, no data_valid
  - bit captured as the new slot 0; slot_idx <= 1; stays in COLLECT
- COLLECT, !bit_valid: state held indefinitely, with no timeout. Gaps between slots are legal.
- Latency: data_out and data_valid appear in the cycle after the final slot bit is sampled (1 cycle).
- Back-to-back frames: frame_start on the cycle after the final slot is accepted without error. Zero idle cycles are required.
- Shadow bits beyond the current slot_idx never reach data_out.
- Reset mid-frame: partial frame is lost. data_out clears to 0 and no data_valid is issued.

Decomposition:
- Shared package (mux_pkg): WIDTH default constant, the IDXW derivation function, and the state enum (ST_IDLE, ST_COLLECT).
- One natural sub-module: slot_demux_reg. It is a registered 1-to-WIDTH write-decoder: given idx, write enable and bit, it updates the one addressed shadow bit.
- The FSM, counter and output register stay in the top module.

Test Plan:
- Reset then 0xAA frame: frame_start on slot 0, bits 0,1,0,1,0,1,0,1 on consecutive cycles -> data_out = 0xAA. data_valid is a single pulse one cycle after slot 7. frame_err stays 0.
- 0xD3 frame with gaps: bits 1,1,0,0,1,0,1,1 with bit_valid low for 2 cycles between slots 3 and 4 -> data_out = 0xD3. busy stays high throughout the gap.
- Back-to-back frames: 0xAA immediately followed by 0xD3 -> two data_valid pulses 8 cycles apart, with values 0xAA then 0xD3.
- Abort: frame_start at slot 5 of a frame, then a full 0x3C frame starting there -> frame_err pulses once. The next data_valid shows 0x3C; the old data_out holds until then.
- Stray bits and reset: bit_valid pulses in IDLE without frame_start leave busy=0 and data_out unchanged. rst asserted mid-frame at slot 4 -> all outputs 0 immediately (asynchronous). A following 0xFF frame then completes normally.
